vec_alu_pipe: RTL and testbench

- Next-generation vector ALU for the filter GPU datapath.
- Parametrised in lane count V and lane width N, with registered outputs and a valid/ready handshake on both sides.
- Per-lane flags are exported alongside the lane-0 flags.
- Horizontal reduction (sum of all A lanes) runs as a sequential multi-cycle operation, one lane per cycle, so the adder depth does not grow with V.

---
 rtl/vec_alu_pipe.sv | 177 +++++++++++++++++
 tb/tb_vec_alu_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_pipe.sv
// Pipelined V-lane, N-bit vector ALU with valid/ready handshakes on both sides.
// Horizontal reduction of the A lanes runs sequentially, one lane per cycle.
module vec_alu_pipe #(
  parameter int unsigned N = 18,
  parameter int unsigned V = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [V*N-1:0]   A,
  input  logic [V*N-1:0]   B,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [V*N-1:0]   Result,
  output logic [3:0]       F,
  output logic [4*V-1:0]   lane_flags,
  output logic             busy
);

  localparam logic [2:0] OpAdd    = 3'b000;
  localparam logic [2:0] OpSub    = 3'b001;
  localparam logic [2:0] OpAnd    = 3'b010;
  localparam logic [2:0] OpOr     = 3'b011;
  localparam logic [2:0] OpXor    = 3'b100;
  localparam logic [2:0] OpReduce = 3'b101;
  localparam logic [2:0] OpSll    = 3'b110;
  localparam logic [2:0] OpSrl    = 3'b111;

  localparam int unsigned IdxW = (V > 1) ? $clog2(V) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(V - 1);
  localparam logic [N-1:0] NVal = N'(N);

  typedef enum logic [0:0] {StIdle, StReduce} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [N-1:0]        acc_q, acc_d;
  logic                sc_q, sc_d;
  logic                sv_q, sv_d;
  logic [V*N-1:0]      a_q, a_d;
  logic                out_valid_q, out_valid_d;
  logic [V*N-1:0]      result_q, result_d;
  logic [4*V-1:0]      lflags_q, lflags_d;

  logic [V-1:0][N+3:0] lane_res;
  logic                accept;
  logic [N-1:0]        a_lane;
  logic [N:0]          step_sum;
  logic                step_ovf;

  // Returns {overflow, carry, zero, negative, result}.
  function automatic logic [N+3:0] lane_op(input logic [2:0] opc, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    logic [N:0]   sum;
    logic [N-1:0] r;
    logic         c;
    logic         v;
    sum = '0;
    r   = a;
    c   = 1'b0;
    v   = 1'b0;
    case (opc)
      OpAdd: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[N-1:0];
        c   = sum[N];
        v   = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      OpSub: begin
        r = a - b;
        c = (a >= b);
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      OpAnd:   r = a & b;
      OpOr:    r = a | b;
      OpXor:   r = a ^ b;
      OpSll:   r = (b >= NVal) ? '0 : (a << b);
      OpSrl:   r = (b >= NVal) ? '0 : (a >> b);
      default: r = a;  // single-lane reduce passes lane 0 straight through
    endcase
    return {v, c, (r == '0), r[N-1], r};
  endfunction

  always_comb begin
    for (int i = 0; i < int'(V); i++) begin
      lane_res[i] = lane_op(op, A[i*N +: N], B[i*N +: N]);
    end
  end

  assign in_ready = !rst && (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign a_lane   = a_q[idx_q*N +: N];
  assign step_sum = {1'b0, acc_q} + {1'b0, a_lane};
  assign step_ovf = (acc_q[N-1] == a_lane[N-1]) && (step_sum[N-1] != acc_q[N-1]);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    sc_d        = sc_q;
    sv_d        = sv_q;
    a_d         = a_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    lflags_d    = lflags_q;

    if (accept) begin
      if (op == OpReduce && V > 1) begin
        state_d = StReduce;
        acc_d   = A[N-1:0];
        idx_d   = IdxW'(1);
        sc_d    = 1'b0;
        sv_d    = 1'b0;
        a_d     = A;
      end else begin
        out_valid_d = 1'b1;
        for (int i = 0; i < int'(V); i++) begin
          result_d[i*N +: N] = lane_res[i][N-1:0];
          lflags_d[i*4 +: 4] = lane_res[i][N+3:N];
        end
      end
    end else if (state_q == StReduce) begin
      if (idx_q != LastIdx) begin
        acc_d = step_sum[N-1:0];
        sc_d  = sc_q | step_sum[N];
        sv_d  = sv_q | step_ovf;
        idx_d = idx_q + IdxW'(1);
      end else if (!out_valid_q || out_ready) begin
        // Final lane is added only once the output slot is free.
        out_valid_d     = 1'b1;
        state_d         = StIdle;
        acc_d           = step_sum[N-1:0];
        sc_d            = sc_q | step_sum[N];
        sv_d            = sv_q | step_ovf;
        result_d        = '0;
        result_d[N-1:0] = step_sum[N-1:0];
        lflags_d        = {V{4'b0010}};
        lflags_d[3:0]   = {sv_q | step_ovf, sc_q | step_sum[N],
                           (step_sum[N-1:0] == '0), step_sum[N-1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      acc_q       <= '0;
      sc_q        <= 1'b0;
      sv_q        <= 1'b0;
      a_q         <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      lflags_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      sc_q        <= sc_d;
      sv_q        <= sv_d;
      a_q         <= a_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      lflags_q    <= lflags_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign Result     = result_q;
  assign lane_flags = lflags_q;
  assign F          = lflags_q[3:0];
  assign busy       = (state_q == StReduce);

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Directed self-checking bench for vec_alu_pipe at N=18, V=3.
module tb_vec_alu_pipe;

  localparam int N = 18;
  localparam int V = 3;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [V*N-1:0] A;
  logic [V*N-1:0] B;
  logic [2:0]     op;
  logic           out_valid;
  logic           out_ready;
  logic [V*N-1:0] Result;
  logic [3:0]     F;
  logic [4*V-1:0] lane_flags;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  vec_alu_pipe #(
    .N(N),
    .V(V)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .F         (F),
    .lane_flags(lane_flags),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [V*N-1:0] pk(input logic [N-1:0] l2, input logic [N-1:0] l1,
                                        input logic [N-1:0] l0);
    return {l2, l1, l0};
  endfunction

  // Called just after a falling edge; returns at the next falling edge.
  task automatic send(input logic [V*N-1:0] a, input logic [V*N-1:0] b, input logic [2:0] o);
    A = a;
    B = b;
    op = o;
    in_valid = 1'b1;
    #1 check("send_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic reduce(input logic [V*N-1:0] a, input logic [V*N-1:0] exp_res,
                        input logic [4*V-1:0] exp_fl);
    int lat;
    lat = 0;
    A = a;
    B = '0;
    op = 3'b101;
    in_valid = 1'b1;
    #1 check("red_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      check("red_busy", busy, 1);
      check("red_in_ready_low", in_ready, 0);
      @(negedge clk);
      lat++;
    end
    check("red_latency", lat, V - 1);
    check("red_result", Result, exp_res);
    check("red_lane_flags", lane_flags, exp_fl);
    check("red_f", F, exp_fl[3:0]);
    check("red_busy_done", busy, 0);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    op = 3'b000;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", Result, 0);
    check("rst_f", F, 0);
    check("rst_lane_flags", lane_flags, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    #1 check("post_rst_in_ready", in_ready, 1);

    // Add with carry-out to zero in lane 0, plain add in lane 1
    send(pk(0, 2, 18'h3FFFF), pk(0, 3, 1), 3'b000);
    check("add_valid", out_valid, 1);
    check("add_result", Result, pk(0, 5, 0));
    check("add_f", F, 4'b0110);
    check("add_lane_flags", lane_flags, 12'h206);

    send(pk(0, 0, 18'h1FFFF), pk(0, 0, 1), 3'b000);
    check("add_ovf_res", Result[N-1:0], 18'h20000);
    check("add_ovf_f", F, 4'b1001);

    send(pk(0, 0, 5), pk(0, 0, 7), 3'b001);
    check("sub_borrow_res", Result[N-1:0], 18'h3FFFE);
    check("sub_borrow_f", F, 4'b0001);

    send(pk(0, 0, 7), pk(0, 0, 5), 3'b001);
    check("sub_res", Result[N-1:0], 2);
    check("sub_f", F, 4'b0100);

    send(pk(0, 0, 18'h0F0F0), pk(0, 0, 18'h0FF00), 3'b010);
    check("and_res", Result[N-1:0], 18'h0F000);
    send(pk(0, 0, 18'h0F0F0), pk(0, 0, 18'h0FF00), 3'b011);
    check("or_res", Result[N-1:0], 18'h0FFF0);
    send(pk(0, 0, 18'h0F0F0), pk(0, 0, 18'h0FF00), 3'b100);
    check("xor_res", Result[N-1:0], 18'h00FF0);

    send(pk(0, 0, 1), pk(0, 0, 17), 3'b110);
    check("sll17_res", Result[N-1:0], 18'h20000);
    check("sll17_f", F, 4'b0001);
    send(pk(0, 0, 1), pk(0, 0, 18), 3'b110);
    check("sll18_res", Result[N-1:0], 0);
    check("sll18_f", F, 4'b0010);
    send(pk(0, 18'h3, 18'h20000), pk(0, 18, 17), 3'b111);
    check("srl_res", Result, pk(0, 0, 1));
    check("srl_f", F, 4'b0000);

    reduce(pk(30, 20, 10), pk(0, 0, 60), 12'h220);
    reduce(pk(0, 1, 18'h3FFFF), pk(0, 0, 0), 12'h226);

    // Backpressure: hold the result, ignore a queued op, then consume+accept together
    send(pk(0, 0, 1), pk(0, 0, 1), 3'b000);
    out_ready = 1'b0;
    A = pk(0, 0, 3);
    B = pk(0, 0, 4);
    op = 3'b000;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_result", Result, pk(0, 0, 2));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("bp_release_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", out_valid, 1);
    check("bp_next_result", Result, pk(0, 0, 7));
    @(negedge clk);
    check("drain_valid", out_valid, 0);
    check("drain_hold", Result, pk(0, 0, 7));

    // Reset in the middle of a reduction
    A = pk(3, 2, 1);
    op = 3'b101;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("abort_busy_pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_result", Result, 0);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_stale", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
